ks_add_arbiter: RTL and testbench

- Shares one registered 16-bit Kogge-Stone adder among NREQ independent requesters.
- Each requester issues operand pairs through a valid/ready handshake.
- Round-robin arbitration issues at most one operation per cycle. The winner's operands are registered into the adder, and an ID tag pipeline tracks each operation so its 17-bit sum returns to the correct requester.
- Sits between requester blocks and the KS adder instance; the adder is external and connected via add_x/add_y/add_s.

---
 rtl/ks_add_arbiter.sv | 118 +++++++++++
 tb/tb_ks_add_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ks_add_arbiter.sv
// ks_add_arbiter: round-robin front end that shares one external KS adder
// among NREQ requesters. Winner operands are registered onto add_x/add_y and
// an ID tag pipeline (ADD_LAT stages) steers each sum back to its requester.
// Optional build macro KS_ARB_STATS_EN adds per-requester saturating response
// counters on stat_cnt.
module ks_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int ADD_LAT = 1,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*W-1:0]    req_x,
  input  logic [NREQ*W-1:0]    req_y,
  output logic [W-1:0]         add_x,
  output logic [W-1:0]         add_y,
  input  logic [W:0]           add_s,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [W:0]           rsp_sum,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
`ifdef KS_ARB_STATS_EN
  ,output logic [NREQ*16-1:0]  stat_cnt
`endif
);

  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     idx;
  logic [IDW-1:0]     grant_id;
  logic               grant_v;
  logic [ADD_LAT-1:0] tag_v;
  logic [IDW-1:0]     tag_id [ADD_LAT];

  // Round-robin search from ptr, wrapping modulo NREQ; first valid wins.
  // req_ready is forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    grant_v   = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!grant_v && req_valid[idx]) begin
        grant_v  = 1'b1;
        grant_id = idx;
      end
    end
    if (grant_v && rst) req_ready[grant_id] = 1'b1;
  end

  // Operand register and pointer advance on a transfer; both hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      add_x <= '0;
      add_y <= '0;
    end else if (grant_v) begin
      add_x <= req_x[grant_id*W +: W];
      add_y <= req_y[grant_id*W +: W];
      ptr   <= IDW'((int'(grant_id) + 1) % NREQ);
    end
  end

  // Tag pipeline: never stalls, final stage lines up with add_s.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v <= '0;
      for (int s = 0; s < ADD_LAT; s++) tag_id[s] <= '0;
    end else begin
      tag_v[0]  <= grant_v;
      tag_id[0] <= grant_id;
      for (int s = 1; s < ADD_LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  // Response register; sum and id keep their last value between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
    end else if (tag_v[ADD_LAT-1]) begin
      rsp_valid <= NREQ'(1) << tag_id[ADD_LAT-1];
      rsp_sum   <= add_s;
      rsp_id    <= tag_id[ADD_LAT-1];
    end else begin
      rsp_valid <= '0;
    end
  end

  // Anything still in the tag pipe or sitting in the response register.
  always_comb begin
    busy = (|tag_v) | (|rsp_valid);
  end

`ifdef KS_ARB_STATS_EN
  // Per-requester completed-response counters, saturating at all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && (stat_cnt[i*16 +: 16] != 16'hFFFF))
          stat_cnt[i*16 +: 16] <= stat_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ks_add_arbiter.sv
// Directed bench for ks_add_arbiter (NREQ=4, W=16, ADD_LAT=1). The external
// adder is modelled as a plain combinational sum of add_x and add_y.
module tb_ks_add_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int LAT  = 1;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [W-1:0]    add_x;
  logic [W-1:0]    add_y;
  logic [W:0]      add_s;
  logic [NREQ-1:0] rsp_valid;
  logic [W:0]      rsp_sum;
  logic [1:0]      rsp_id;
  logic            busy;
`ifdef KS_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ks_add_arbiter #(.NREQ(NREQ), .W(W), .ADD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .add_x(add_x), .add_y(add_y),
    .add_s(add_s), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum),
    .rsp_id(rsp_id), .busy(busy)
`ifdef KS_ARB_STATS_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  assign add_s = {1'b0, add_x} + {1'b0, add_y};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    req_valid = '0;
    step();
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_valid = 4'hF;
    req_x = '0;
    req_y = '0;
    step();
    step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (add_x !== 16'h0000) begin errors++; $display("FAIL reset_add_x got %h exp 0000", add_x); end
    checks++; if (add_y !== 16'h0000) begin errors++; $display("FAIL reset_add_y got %h exp 0000", add_y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b exp 0001", req_ready); end
    req_valid = '0;
    #1;
  endtask

  task automatic test_single;
    req_x[2*W +: W] = 16'hFFFF;
    req_y[2*W +: W] = 16'h0001;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    step();
    req_valid = '0;
    #1;
    checks++; if (add_x !== 16'hFFFF) begin errors++; $display("FAIL single_add_x got %h exp ffff", add_x); end
    checks++; if (add_y !== 16'h0001) begin errors++; $display("FAIL single_add_y got %h exp 0001", add_y); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp got %b exp 0000", rsp_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    step();
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid got %b exp 0100", rsp_valid); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id got %0d exp 2", rsp_id); end
    checks++; if (rsp_sum !== 17'h10000) begin errors++; $display("FAIL single_rsp_sum got %h exp 10000", rsp_sum); end
    step();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_clear got %b exp 0000", rsp_valid); end
    checks++; if (rsp_sum !== 17'h10000) begin errors++; $display("FAIL single_sum_hold got %h exp 10000", rsp_sum); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", busy); end
  endtask

  task automatic test_round_robin;
    logic [W:0] exp_sum [4];
    logic [3:0] exp_oh  [4];
    exp_sum[0] = 17'h0FFFF; exp_sum[1] = 17'h10000;
    exp_sum[2] = 17'h10001; exp_sum[3] = 17'h10002;
    exp_oh[0] = 4'b0001; exp_oh[1] = 4'b0010;
    exp_oh[2] = 4'b0100; exp_oh[3] = 4'b1000;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*W +: W] = 16'hAAAA;
      req_y[i*W +: W] = 16'h5555 + 16'(i);
    end
    req_valid = 4'hF;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) begin req_valid = '0; #1; end
      if (c < 8) begin
        checks++; if (req_ready !== exp_oh[c%4]) begin errors++; $display("FAIL rr_grant c=%0d got %b exp %b", c, req_ready, exp_oh[c%4]); end
      end else begin
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_idle_grant c=%0d got %b exp 0000", c, req_ready); end
      end
      if (c >= 2) begin
        checks++; if (rsp_valid !== exp_oh[(c-2)%4]) begin errors++; $display("FAIL rr_rsp_valid c=%0d got %b exp %b", c, rsp_valid, exp_oh[(c-2)%4]); end
        checks++; if (rsp_id !== 2'((c-2)%4)) begin errors++; $display("FAIL rr_rsp_id c=%0d got %0d exp %0d", c, rsp_id, (c-2)%4); end
        checks++; if (rsp_sum !== exp_sum[(c-2)%4]) begin errors++; $display("FAIL rr_rsp_sum c=%0d got %h exp %h", c, rsp_sum, exp_sum[(c-2)%4]); end
      end
      step();
    end
  endtask

  task automatic test_fairness;
    logic [3:0] v;
    logic [3:0] exp_rdy;
    int wait_c [4];
    int mptr;
    int g;
    do_reset();
    req_valid = 4'b0001;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fair_solo c=%0d got %b exp 0001", c, req_ready); end
      step();
    end
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL fair_late_req got %b exp 1000", req_ready); end
    step();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fair_back_to_0 got %b exp 0001", req_ready); end
    req_valid = '0;
    step();
    // Random phase: a requester holds valid until granted; ptr is 0 again.
    v = '0;
    mptr = 0;
    for (int i = 0; i < 4; i++) wait_c[i] = 0;
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < 4; i++)
        if (!v[i] && $urandom_range(0, 2) == 0) v[i] = 1'b1;
      req_valid = v;
      #1;
      g = -1;
      for (int k = 0; k < 4; k++)
        if (g < 0 && v[(mptr + k) % 4]) g = (mptr + k) % 4;
      exp_rdy = (g < 0) ? 4'b0000 : (4'b0001 << g);
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL fair_rand_grant c=%0d got %b exp %b", c, req_ready, exp_rdy); end
      step();
      if (g >= 0) begin
        checks++; if (wait_c[g] > NREQ - 1) begin errors++; $display("FAIL fair_starve req=%0d waited %0d max %0d", g, wait_c[g], NREQ - 1); end
        v[g] = 1'b0;
        wait_c[g] = 0;
        mptr = (g + 1) % 4;
      end
      for (int i = 0; i < 4; i++) if (v[i]) wait_c[i]++;
    end
    req_valid = '0;
    step();
    step();
  endtask

  task automatic test_reset_midflight;
    do_reset();
    req_x[1*W +: W] = 16'h1234;
    req_y[1*W +: W] = 16'h4321;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
    rst = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_reset got %b exp 0", busy); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp_reset got %b exp 0000", rsp_valid); end
    step();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_stale_rsp c=%0d got %b exp 0000", c, rsp_valid); end
      checks++; if (rsp_sum === 17'h05555) begin errors++; $display("FAIL mid_stale_sum c=%0d got %h must not be 05555", c, rsp_sum); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after c=%0d got %b exp 0", c, busy); end
    end
  endtask

`ifdef KS_ARB_STATS_EN
  task automatic test_stats;
    do_reset();
    req_x[1*W +: W] = 16'h0001;
    req_y[1*W +: W] = 16'h0002;
    req_valid = 4'b0010;
    step(); step(); step();
    req_valid = '0;
    step(); step(); step();
    checks++; if (stat_cnt[31:16] !== 16'd3) begin errors++; $display("FAIL stats_req1 got %0d exp 3", stat_cnt[31:16]); end
    checks++; if (stat_cnt[15:0] !== 16'd0) begin errors++; $display("FAIL stats_req0 got %0d exp 0", stat_cnt[15:0]); end
  endtask
`endif

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_reset_midflight();
`ifdef KS_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
